module_bus_arbiter: RTL and testbench

MODULE_BUS_ARBITER -- requirements
Module: module_bus_arbiter

---
 rtl/module_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_module_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/module_bus_arbiter.sv
// Round-robin arbiter granting N_REQ requesters access to a shared module register bus.
// Latency: acceptance (req_ready_o) in the IDLE cycle, bus access next cycle, rsp_valid_o 2 cycles after acceptance.
// Backpressure: one transaction in flight; requests hold valid until req_ready_o, one grant per 3 cycles.
module module_bus_arbiter #(
    parameter int N_MODULES = 4,
    parameter int N_REQ     = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [N_REQ-1:0]     req_we_i,
    input  logic [3*N_REQ-1:0]   req_addr_i,
    input  logic [32*N_REQ-1:0]  req_wdata_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [N_REQ-1:0]     rsp_valid_o,
    output logic [31:0]          rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 we_o,
    output logic [2:0]           addr_o,
    output logic [31:0]          wdata_o,
    input  logic [31:0]          rdata_i
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q;
    logic [PW-1:0]      rr_ptr_q;
    logic [PW-1:0]      owner_q;
    logic               txn_we_q;
    logic               txn_err_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [31:0]        rsp_data_q;
    logic               rsp_err_q;
    logic               bus_we_q;
    logic [2:0]         bus_addr_q;
    logic [31:0]        bus_wdata_q;

    logic               found;
    logic [PW-1:0]      winner;
    logic [PW-1:0]      idx;
    logic               win_we;
    logic [2:0]         win_addr;
    logic [31:0]        win_wdata;
    logic               win_addr_ok;

    // Round-robin search starting at rr_ptr_q, first valid requester wins
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PW'((int'(rr_ptr_q) + i) % N_REQ);
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Winner's request fields; module addresses 1..N_MODULES exist, 0 and above are errors
    always_comb begin
        win_we      = req_we_i[winner];
        win_addr    = req_addr_i[int'(winner)*3 +: 3];
        win_wdata   = req_wdata_i[int'(winner)*32 +: 32];
        win_addr_ok = (win_addr != 3'd0) && (int'({29'd0, win_addr}) <= N_MODULES);
    end

    // Acceptance pulse is combinational so the requester sees it in the arbitration cycle
    always_comb begin
        req_ready_o = '0;
        if (!wb_rst_i && (state_q == IDLE) && found) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    // Transaction FSM; bus and response outputs are registers so reset clears them at once
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            txn_we_q    <= 1'b0;
            txn_err_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rsp_valid_q <= '0;
                    if (found) begin
                        owner_q     <= winner;
                        txn_we_q    <= win_we;
                        txn_err_q   <= !win_addr_ok;
                        bus_we_q    <= win_we && win_addr_ok;
                        bus_addr_q  <= win_addr;
                        bus_wdata_q <= win_wdata;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Writes and bad addresses report zero data
                    rsp_data_q  <= (txn_we_q || txn_err_q) ? 32'd0 : rdata_i;
                    rsp_err_q   <= txn_err_q;
                    rsp_valid_q <= N_REQ'(1) << owner_q;
                    bus_we_q    <= 1'b0;
                    bus_addr_q  <= '0;
                    bus_wdata_q <= '0;
                    state_q     <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    rr_ptr_q    <= (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign we_o        = bus_we_q;
    assign addr_o      = bus_addr_q;
    assign wdata_o     = bus_wdata_q;

endmodule

// File: tb/tb_module_bus_arbiter.sv
// Directed bench for module_bus_arbiter with a response scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Expected responses are queued at acceptance and checked when rsp_valid_o pulses.
module tb_module_bus_arbiter;

    localparam int NM = 4;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_we;
    logic [3*NR-1:0] req_addr;
    logic [32*NR-1:0] req_wdata;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [31:0]     rsp_data;
    logic            rsp_err;
    logic            we;
    logic [2:0]      addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;

    typedef struct packed {
        logic [1:0]  oh;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // Decoder model: read data as a function of the module address on the bus
    function automatic logic [31:0] rd_model(input logic [2:0] a);
        if (a == 3'd4) return 32'h1234_5678;
        return 32'h0BAD_0000 | {29'd0, a};
    endfunction

    assign rdata = rd_model(addr);

    module_bus_arbiter #(.N_MODULES(NM), .N_REQ(NR)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .req_valid_i (req_valid),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .we_o        (we),
        .addr_o      (addr),
        .wdata_o     (wdata),
        .rdata_i     (rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Falling-edge sample point; any response pulse is matched against the scoreboard
    task automatic sample();
        rsp_t e;
        @(negedge clk);
        if (|rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {62'd0, rsp_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_owner", {62'd0, rsp_valid}, {62'd0, e.oh});
                chk("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rsp_t mk(input logic [1:0] oh, input logic [31:0] d, input logic er);
        rsp_t r;
        r.oh = oh; r.data = d; r.err = er;
        return r;
    endfunction

    initial begin
        rst = 1'b1;
        req_valid = 2'b11; req_we = '0; req_addr = '0; req_wdata = '0;

        // Reset: every output held at zero even with requests pending
        sample();
        chk("rst_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("rst_we", {63'd0, we}, 64'd0);
        chk("rst_addr", {61'd0, addr}, 64'd0);
        chk("rst_wdata", {32'd0, wdata}, 64'd0);
        req_valid = '0;
        tick(); rst = 1'b0;
        tick();

        // Single write from req0 to module 2
        req_valid = 2'b01; req_we = 2'b01; req_addr[2:0] = 3'd2; req_wdata[31:0] = 32'hDEAD_BEEF;
        sample();
        chk("wr_ready", {62'd0, req_ready}, 64'd1);
        exp_q.push_back(mk(2'b01, 32'd0, 1'b0));
        tick();
        req_valid = '0; req_we = '0; req_addr[2:0] = 3'd7; req_wdata[31:0] = '0;
        sample();
        chk("wr_we", {63'd0, we}, 64'd1);
        chk("wr_addr", {61'd0, addr}, 64'd2);
        chk("wr_wdata", {32'd0, wdata}, 64'hDEAD_BEEF);
        chk("wr_ready_access", {62'd0, req_ready}, 64'd0);
        tick();
        sample();
        chk("wr_rsp_valid", {62'd0, rsp_valid}, 64'd1);
        chk("wr_we_resp", {63'd0, we}, 64'd0);
        tick();

        // Single read from req1 to module 4
        req_valid = 2'b10; req_we = 2'b00; req_addr[5:3] = 3'd4;
        sample();
        chk("rd_ready", {62'd0, req_ready}, 64'd2);
        exp_q.push_back(mk(2'b10, 32'h1234_5678, 1'b0));
        tick();
        req_valid = '0;
        sample();
        chk("rd_we", {63'd0, we}, 64'd0);
        chk("rd_addr", {61'd0, addr}, 64'd4);
        tick();
        sample();
        chk("rd_rsp_valid", {62'd0, rsp_valid}, 64'd2);
        tick();

        // Contention from reset: grants alternate, three cycles apart
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 2'b11; req_we = 2'b00; req_addr = {3'd3, 3'd1};
        for (int g = 0; g < 4; g++) begin
            sample();
            chk($sformatf("cont_grant%0d", g), {62'd0, req_ready}, (g % 2 == 0) ? 64'd1 : 64'd2);
            exp_q.push_back(mk((g % 2 == 0) ? 2'b01 : 2'b10, rd_model((g % 2 == 0) ? 3'd1 : 3'd3), 1'b0));
            tick();
            sample();
            chk($sformatf("cont_gap_a%0d", g), {62'd0, req_ready}, 64'd0);
            tick();
            sample();
            chk($sformatf("cont_gap_b%0d", g), {62'd0, req_ready}, 64'd0);
            if (g == 3) req_valid = '0;
            tick();
        end

        // Address errors: module 0 and module 5 writes
        req_valid = 2'b01; req_we = 2'b01; req_addr[2:0] = 3'd0; req_wdata[31:0] = 32'hFFFF_FFFF;
        sample();
        chk("err0_ready", {62'd0, req_ready}, 64'd1);
        exp_q.push_back(mk(2'b01, 32'd0, 1'b1));
        tick();
        req_valid = '0;
        sample();
        chk("err0_we", {63'd0, we}, 64'd0);
        tick();
        sample();
        chk("err0_rsp_valid", {62'd0, rsp_valid}, 64'd1);
        tick();
        req_valid = 2'b01; req_addr[2:0] = 3'd5;
        sample();
        chk("err5_ready", {62'd0, req_ready}, 64'd1);
        exp_q.push_back(mk(2'b01, 32'd0, 1'b1));
        tick();
        req_valid = '0;
        sample();
        chk("err5_we", {63'd0, we}, 64'd0);
        chk("err5_addr", {61'd0, addr}, 64'd5);
        tick();
        sample();
        tick();

        // Reset during the ACCESS cycle of a write aborts it
        req_valid = 2'b01; req_we = 2'b01; req_addr[2:0] = 3'd3; req_wdata[31:0] = 32'hCAFE_F00D;
        sample();
        chk("abort_ready", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid = '0;
        sample();
        chk("abort_we_before", {63'd0, we}, 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_we_after", {63'd0, we}, 64'd0);
        chk("abort_addr_after", {61'd0, addr}, 64'd0);
        tick(); rst = 1'b0;
        sample();
        chk("abort_no_rsp", {62'd0, rsp_valid}, 64'd0);
        tick();
        req_valid = 2'b11; req_we = 2'b00; req_addr = {3'd2, 3'd1};
        sample();
        chk("abort_next_grant", {62'd0, req_ready}, 64'd1);
        exp_q.push_back(mk(2'b01, rd_model(3'd1), 1'b0));
        tick();
        req_valid = '0;
        sample(); tick();
        sample(); tick();

        // Late request: req1 raised during req0's RESP cycle
        req_valid = 2'b01; req_we = 2'b00; req_addr = {3'd1, 3'd2};
        sample();
        chk("late_req0_ready", {62'd0, req_ready}, 64'd1);
        exp_q.push_back(mk(2'b01, rd_model(3'd2), 1'b0));
        tick();
        req_valid = '0;
        sample();
        tick();
        req_valid = 2'b10;
        sample();
        chk("late_wait_in_resp", {62'd0, req_ready}, 64'd0);
        tick();
        sample();
        chk("late_req1_ready", {62'd0, req_ready}, 64'd2);
        exp_q.push_back(mk(2'b10, rd_model(3'd1), 1'b0));
        tick();
        req_valid = '0;
        sample(); tick();
        sample(); tick();
        sample(); tick();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
